// File: rtl/serial_word_shifter_pkg.sv
// rtl/serial_word_shifter_pkg.sv - shared types and defaults for the serial word shifter
// Package ser_pkg: FSM state encoding and default word/gap sizes shared by
// the interface, the holding register and the top.
package ser_pkg;

  localparam int SER_WIDTH_DEF = 8;
  localparam int SER_GAP_DEF   = 1;

  // ST_PAR is only reachable when the parity build option is enabled.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } ser_state_t;

endpackage

// File: rtl/serial_word_shifter_if.sv
// rtl/serial_word_shifter_if.sv - word valid/ready handshake bundle
// Ports:
//   word_valid  upstream word available
//   word_data   WIDTH-bit word, sampled only on handshake
//   word_ready  shifter can take a word (holding register empty)
// Modports: master = upstream word source, slave = serial_word_shifter.
interface serial_word_shifter_if
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) ();

  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             word_ready;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );

endinterface

// File: rtl/serial_word_shifter_hold_reg.sv
// rtl/serial_word_shifter_hold_reg.sv - single-entry word holding register
// Module ser_hold_reg: buffers one accepted word so the next word can be
// taken while the current one shifts.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_data (accepted handshake)
//   load_data    word to capture
//   unload       shifter has taken hold_data this cycle
//   hold_vld     hold_data holds an untaken word
//   hold_data    held word
//   ready        = !hold_vld, registered-derived (no path from load)
module ser_hold_reg
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             unload,
  output logic             hold_vld,
  output logic [WIDTH-1:0] hold_data,
  output logic             ready
);

  assign ready = !hold_vld;

  // A load on the same edge as an unload keeps the entry full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (load) begin
      hold_vld  <= 1'b1;
      hold_data <= load_data;
    end else if (unload) begin
      hold_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_shifter.sv
// rtl/serial_word_shifter.sv - parallel-to-serial word source with framing strobes
// Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit
// per clock on ser_out, followed by GAP idle zero bits.
// Build option: SER_PARITY_EN appends one even-parity bit to every frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   word         serial_word_shifter_if.slave (word_valid/word_data/word_ready)
//   ser_out      serial bit, 0 outside frames
//   ser_frame    high on data/parity bits
//   ser_last     high on the final bit of a frame
//   busy         frame/gap in progress or a word is held
//   tx_count     saturating count of completed frames
module serial_word_shifter
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter int GAP       = SER_GAP_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter int COUNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_word_shifter_if.slave word,
  output logic                 ser_out,
  output logic                 ser_frame,
  output logic                 ser_last,
  output logic                 busy,
  output logic [COUNT_W-1:0]   tx_count
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ser_out_d, frame_d, last_d;
  logic             start, frame_done;

  logic             hold_vld, unload, accept;
  logic [WIDTH-1:0] hold_data;

`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign accept = word.word_valid && word.word_ready;

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (word.word_data),
    .unload    (unload),
    .hold_vld  (hold_vld),
    .hold_data (hold_data),
    .ready     (word.word_ready)
  );

  assign busy = (state_q != ST_IDLE) || hold_vld;

  // Outputs are computed here for the coming cycle and registered below, so
  // ser_out shows the bit selected at the previous edge. sh_q holds the bits
  // not yet shown; bit_q counts how many of them remain.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    ser_out_d  = 1'b0;
    frame_d    = 1'b0;
    last_d     = 1'b0;
    unload     = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
`ifdef SER_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      ST_IDLE: start = hold_vld;

      ST_SHIFT: begin
        if (bit_q != '0) begin
          ser_out_d = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
          sh_d      = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
          bit_d     = bit_q - 1'b1;
          frame_d   = 1'b1;
`ifndef SER_PARITY_EN
          last_d    = (bit_q == BIT_W'(1));
`endif
        end else begin
`ifdef SER_PARITY_EN
          state_d   = ST_PAR;
          ser_out_d = par_q;
          frame_d   = 1'b1;
          last_d    = 1'b1;
`else
          frame_done = 1'b1;
`endif
        end
      end

`ifdef SER_PARITY_EN
      ST_PAR: frame_done = 1'b1;
`endif

      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
          start   = hold_vld;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // End of the final frame bit: idle gap first, otherwise chain straight
    // into the held word so GAP=0 gives a gapless stream.
    if (frame_done) begin
      if (GAP > 0) begin
        state_d = ST_GAP;
        gap_d   = GAP_W'(GAP - 1);
      end else begin
        state_d = ST_IDLE;
        start   = hold_vld;
      end
    end

    if (start) begin
      unload    = 1'b1;
      state_d   = ST_SHIFT;
      ser_out_d = MSB_FIRST ? hold_data[WIDTH-1] : hold_data[0];
      sh_d      = MSB_FIRST ? {hold_data[WIDTH-2:0], 1'b0} : {1'b0, hold_data[WIDTH-1:1]};
      bit_d     = BIT_W'(WIDTH - 1);
      frame_d   = 1'b1;
`ifdef SER_PARITY_EN
      par_d     = ^hold_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      ser_out   <= 1'b0;
      ser_frame <= 1'b0;
      ser_last  <= 1'b0;
      tx_count  <= '0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      ser_out   <= ser_out_d;
      ser_frame <= frame_d;
      ser_last  <= last_d;
`ifdef SER_PARITY_EN
      par_q     <= par_d;
`endif
      // Counted as the final bit goes out, so tx_count steps with ser_last.
      if (last_d && (tx_count != '1)) begin
        tx_count <= tx_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_shifter.sv
// tb/tb_serial_word_shifter.sv - self-checking bench for serial_word_shifter
// Instance a: WIDTH=8, GAP=1, MSB first, 16-bit counter.
// Instance b: WIDTH=8, GAP=0, LSB first, 4-bit counter.
module tb_serial_word_shifter;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  serial_word_shifter_if #(.WIDTH(W)) if_a ();
  serial_word_shifter_if #(.WIDTH(W)) if_b ();

  logic        a_out, a_frame, a_last, a_busy;
  logic [15:0] a_cnt;
  logic        b_out, b_frame, b_last, b_busy;
  logic [3:0]  b_cnt;

  serial_word_shifter #(.WIDTH(W), .GAP(1), .MSB_FIRST(1'b1), .COUNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .word(if_a),
    .ser_out(a_out), .ser_frame(a_frame), .ser_last(a_last),
    .busy(a_busy), .tx_count(a_cnt)
  );

  serial_word_shifter #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b0), .COUNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .word(if_b),
    .ser_out(b_out), .ser_frame(b_frame), .ser_last(b_last),
    .busy(b_busy), .tx_count(b_cnt)
  );

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted word becomes a list of output slots (data bits, optional
  // parity, gap zeros). At every edge the next slot is shown; when the list
  // is exhausted the held word, if any, is expanded into a fresh list.
  typedef struct packed {
    logic b;
    logic frame;
    logic last;
    logic active;
  } slot_t;

  slot_t       m_slots [2][16];
  int          m_len [2];
  int          m_pos [2];
  slot_t       m_cur [2];
  logic        m_hold_vld [2];
  logic [7:0]  m_hold [2];
  int          m_cnt [2];

  int          fcyc [2];
  int          ones [2];
  int          rises [2];
  logic        pf [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic bit msb_of(input int k);
    return (k == 0);
  endfunction

  function automatic int cmax_of(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  task automatic model_reset(input int k);
    m_len[k]      = 0;
    m_pos[k]      = 0;
    m_cur[k]      = '0;
    m_hold_vld[k] = 1'b0;
    m_hold[k]     = '0;
    m_cnt[k]      = 0;
  endtask

  task automatic expand(input int k, input logic [7:0] w);
    slot_t s;
    int    n;
    n = 0;
    for (int i = 0; i < W; i++) begin
      s.b      = msb_of(k) ? w[W-1-i] : w[i];
      s.frame  = 1'b1;
      s.last   = (PB == 0) && (i == W - 1);
      s.active = 1'b1;
      m_slots[k][n] = s;
      n++;
    end
    if (PB != 0) begin
      s.b = ^w; s.frame = 1'b1; s.last = 1'b1; s.active = 1'b1;
      m_slots[k][n] = s;
      n++;
    end
    for (int g = 0; g < gap_of(k); g++) begin
      s.b = 1'b0; s.frame = 1'b0; s.last = 1'b0; s.active = 1'b1;
      m_slots[k][n] = s;
      n++;
    end
    m_len[k] = n;
  endtask

  task automatic model_step(input int k);
    logic       v, acc;
    logic [7:0] d;
    if (k == 0) begin
      v = if_a.word_valid; d = if_a.word_data;
    end else begin
      v = if_b.word_valid; d = if_b.word_data;
    end
    acc = v && !m_hold_vld[k];
    if (m_pos[k] < m_len[k]) begin
      m_cur[k] = m_slots[k][m_pos[k]];
      m_pos[k]++;
    end else if (m_hold_vld[k]) begin
      expand(k, m_hold[k]);
      m_hold_vld[k] = 1'b0;
      m_cur[k] = m_slots[k][0];
      m_pos[k] = 1;
    end else begin
      m_cur[k] = '0;
    end
    if (m_cur[k].last && (m_cnt[k] < cmax_of(k))) m_cnt[k]++;
    if (acc) begin
      m_hold[k]     = d;
      m_hold_vld[k] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_a_n);
    if (!rst_a_n) model_reset(0);
    else model_step(0);
  end

  initial forever begin
    @(posedge clk or negedge rst_b_n);
    if (!rst_b_n) model_reset(1);
    else model_step(1);
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_inst(input int k, input string tag, input logic o, input logic f,
                          input logic l, input logic bz, input logic r, input logic [15:0] c);
    check({tag, ".ser_out"},    o,  m_cur[k].b);
    check({tag, ".ser_frame"},  f,  m_cur[k].frame);
    check({tag, ".ser_last"},   l,  m_cur[k].last);
    check({tag, ".busy"},       bz, m_cur[k].active || m_hold_vld[k]);
    check({tag, ".word_ready"}, r,  !m_hold_vld[k]);
    check({tag, ".tx_count"},   c,  m_cnt[k]);
    if (f === 1'b1) begin
      fcyc[k]++;
      if (o === 1'b1) ones[k]++;
      if (pf[k] !== 1'b1) rises[k]++;
    end
    pf[k] = f;
  endtask

  initial forever begin
    @(negedge clk);
    cmp_inst(0, "a", a_out, a_frame, a_last, a_busy, if_a.word_ready, a_cnt);
    cmp_inst(1, "b", b_out, b_frame, b_last, b_busy, if_b.word_ready, {12'b0, b_cnt});
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input int k, input logic v, input logic [7:0] d);
    if (k == 0) begin
      if_a.word_valid = v; if_a.word_data = d;
    end else begin
      if_b.word_valid = v; if_b.word_data = d;
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? if_a.word_ready : if_b.word_ready;
  endfunction

  // Offers d; returns at the negedge just after the accepting edge.
  task automatic put(input int k, input logic [7:0] d, input bit drop);
    bit done;
    done = 1'b0;
    @(negedge clk);
    set_in(k, 1'b1, d);
    for (int i = 0; i < 64 && !done; i++) begin
      if (rdy(k) === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    if (!done) check("put_timeout", 0, 1);
    if (drop) set_in(k, 1'b0, d);
  endtask

  task automatic wait_idle(input int k);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (((k == 0) ? a_busy : b_busy) === 1'b0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic capture(input int k, output logic [15:0] cap, output logic [15:0] lm,
                         output logic [15:0] fm);
    cap = '0; lm = '0; fm = '0;
    for (int i = 0; i < W + PB; i++) begin
      @(negedge clk);
      cap = {cap[14:0], (k == 0) ? a_out : b_out};
      lm  = {lm[14:0], (k == 0) ? a_last : b_last};
      fm  = {fm[14:0], (k == 0) ? a_frame : b_frame};
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] cap, lm, fm;
    logic [15:0] fmask;
    vectors = 0;
    miscompares = 0;
    fmask = (PB != 0) ? 16'h01FF : 16'h00FF;
    for (int k = 0; k < 2; k++) begin
      fcyc[k] = 0; ones[k] = 0; rises[k] = 0; pf[k] = 1'b0;
      model_reset(k);
    end
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("rst.ser_out",    a_out, 0);
    check("rst.ser_frame",  a_frame, 0);
    check("rst.ser_last",   a_last, 0);
    check("rst.busy",       a_busy, 0);
    check("rst.word_ready", if_a.word_ready, 1);
    check("rst.tx_count",   a_cnt, 0);
    #2;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // B4, MSB first, one gap bit
    put(0, 8'hB4, 1'b1);
    capture(0, cap, lm, fm);
`ifdef SER_PARITY_EN
    check("b4.bits", cap, 16'h0168);
`else
    check("b4.bits", cap, 16'h00B4);
`endif
    check("b4.last", lm, 16'h0001);
    check("b4.frame", fm, fmask);
    @(negedge clk);
    check("b4.gap_out", a_out, 0);
    check("b4.gap_frame", a_frame, 0);
    check("b4.gap_busy", a_busy, 1);
    @(negedge clk);
    check("b4.busy_fall", a_busy, 0);
    check("b4.tx_count", a_cnt, 1);

    // FF then 00 with valid held, GAP=0
    put(1, 8'hFF, 1'b0);
    put(1, 8'h00, 1'b1);
    wait_idle(1);
    check("ff00.frame_cycles", fcyc[1], 16 + 2 * PB);
    check("ff00.ones", ones[1], 8);
    check("ff00.contiguous", rises[1], 1);
    check("ff00.tx_count", b_cnt, 2);

    // parity-sensitive words
    put(0, 8'h07, 1'b1);
    capture(0, cap, lm, fm);
`ifdef SER_PARITY_EN
    check("w07.bits", cap, 16'h000F);
`else
    check("w07.bits", cap, 16'h0007);
`endif
    check("w07.last", lm, 16'h0001);
    wait_idle(0);
    put(0, 8'h03, 1'b1);
    capture(0, cap, lm, fm);
`ifdef SER_PARITY_EN
    check("w03.bits", cap, 16'h0006);
`else
    check("w03.bits", cap, 16'h0003);
`endif
    check("w03.last", lm, 16'h0001);
    wait_idle(0);

    // holding register full while word_data keeps changing
    put(0, 8'h5A, 1'b0);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if_a.word_data = 8'(8'h10 + i);
    end
    @(negedge clk);
    if_a.word_valid = 1'b0;
    wait_idle(0);
    check("hold.tx_count", a_cnt, 7);

    // reset in the middle of AA
    put(0, 8'hAA, 1'b1);
    repeat (3) @(negedge clk);
    check("aa.bit3", a_out, 1);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("mid_rst.ser_out",    a_out, 0);
    check("mid_rst.ser_frame",  a_frame, 0);
    check("mid_rst.busy",       a_busy, 0);
    check("mid_rst.word_ready", if_a.word_ready, 1);
    check("mid_rst.tx_count",   a_cnt, 0);
    @(negedge clk);
    #2;
    rst_a_n = 1'b1;
    rises[0] = 0;
    repeat (12) @(negedge clk);
    check("post_rst.no_frames", rises[0], 0);
    check("post_rst.busy", a_busy, 0);

    // 17 words into a 4-bit counter
    @(negedge clk);
    #2;
    rst_b_n = 1'b0;
    @(negedge clk);
    #2;
    rst_b_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      put(1, 8'(i * 13), i == 16);
    end
    wait_idle(1);
    check("sat.tx_count", b_cnt, 15);

    // LSB-first ordering on b
    put(1, 8'hC1, 1'b1);
    capture(1, cap, lm, fm);
`ifdef SER_PARITY_EN
    check("c1.bits", cap, 16'h0107);
`else
    check("c1.bits", cap, 16'h0083);
`endif
    check("c1.last", lm, 16'h0001);
    wait_idle(1);
    check("c1.tx_count", b_cnt, 15);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
